// File: rtl/amo_reservation_tracker_pkg.sv
// Shared types and helpers for the LR/SC reservation tracker.
package amo_reservation_tracker_pkg;

  typedef enum logic [0:0] {
    SLOT_IDLE     = 1'b0,
    SLOT_RESERVED = 1'b1
  } slot_state_e;

  // Number of byte-offset bits below the reservation set tag.
  function automatic int tag_offset_bits(input int words);
    return $clog2(words * 4);
  endfunction

endpackage

// File: rtl/amo_reservation_slot.sv
// One reservation holder: state, set tag, lifetime counter and local match logic.
module amo_reservation_slot
  import amo_reservation_tracker_pkg::*;
#(
  parameter int LR_WAIT = 32,
  parameter int TAG_W   = 27
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_lr_valid,
  input  logic [TAG_W-1:0] i_lr_tag,
  input  logic             i_sc_valid,
  input  logic [TAG_W-1:0] i_sc_tag,
  input  logic             i_store_valid,
  input  logic [TAG_W-1:0] i_store_tag,
  input  logic             i_ext_valid,
  input  logic [TAG_W-1:0] i_ext_tag,
  input  logic             i_peer_kill,
  output logic             o_reserved,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_sc_match
);

  localparam int CNT_W = $clog2(LR_WAIT + 1);

  slot_state_e      r_state;
  logic [TAG_W-1:0] r_tag;
  logic [CNT_W-1:0] r_count;
  logic             w_inval;

  assign w_inval = (i_store_valid && (i_store_tag == r_tag)) ||
                   (i_ext_valid   && (i_ext_tag   == r_tag));

  // An LR is ordered after every other event of its cycle, so it always wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SLOT_IDLE;
      r_tag   <= '0;
      r_count <= '0;
    end else if (i_lr_valid) begin
      r_state <= SLOT_RESERVED;
      r_tag   <= i_lr_tag;
      r_count <= CNT_W'(LR_WAIT);
    end else if (r_state == SLOT_RESERVED) begin
      if (i_sc_valid || w_inval || i_peer_kill || (r_count <= CNT_W'(1))) begin
        r_state <= SLOT_IDLE;
        r_count <= '0;
      end else begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  assign o_reserved = (r_state == SLOT_RESERVED);
  assign o_tag      = r_tag;
  assign o_sc_match = o_reserved && (r_tag == i_sc_tag);

endmodule

// File: rtl/amo_reservation_tracker.sv
// Multi-channel LR/SC reservation tracker with cross-channel invalidation and SC arbitration.
module amo_reservation_tracker
  import amo_reservation_tracker_pkg::*;
#(
  parameter int NUM_CHANNELS      = 2,
  parameter int LR_WAIT           = 32,
  parameter int RESERVATION_WORDS = 8,
  parameter int ADDR_W            = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_CHANNELS-1:0]        i_lr_valid,
  input  logic [NUM_CHANNELS*ADDR_W-1:0] i_lr_addr,
  input  logic [NUM_CHANNELS-1:0]        i_sc_valid,
  input  logic [NUM_CHANNELS*ADDR_W-1:0] i_sc_addr,
  output logic [NUM_CHANNELS-1:0]        o_sc_done,
  output logic [NUM_CHANNELS-1:0]        o_sc_success,
  input  logic                           i_store_valid,
  input  logic [ADDR_W-1:0]              i_store_addr,
  input  logic                           i_ext_inval_valid,
  input  logic [ADDR_W-1:0]              i_ext_inval_addr,
  output logic [NUM_CHANNELS-1:0]        o_reservation_valid
);

  localparam int OFF_W = tag_offset_bits(RESERVATION_WORDS);
  localparam int TAG_W = ADDR_W - OFF_W;

  logic [NUM_CHANNELS-1:0][TAG_W-1:0] w_lr_tag;
  logic [NUM_CHANNELS-1:0][TAG_W-1:0] w_sc_tag;
  logic [NUM_CHANNELS-1:0][TAG_W-1:0] w_slot_tag;
  logic [TAG_W-1:0]                   w_store_tag;
  logic [TAG_W-1:0]                   w_ext_tag;
  logic [NUM_CHANNELS-1:0]            w_sc_match;
  logic [NUM_CHANNELS-1:0]            w_eligible;
  logic [NUM_CHANNELS-1:0]            w_win;
  logic [NUM_CHANNELS-1:0]            w_peer_kill;
  logic [NUM_CHANNELS-1:0]            r_sc_done;
  logic [NUM_CHANNELS-1:0]            r_sc_success;
  logic                               w_unused_offsets;

  always_comb begin
    w_lr_tag = '0;
    w_sc_tag = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      w_lr_tag[i] = i_lr_addr[i*ADDR_W+OFF_W +: TAG_W];
      w_sc_tag[i] = i_sc_addr[i*ADDR_W+OFF_W +: TAG_W];
    end
  end

  assign w_store_tag = i_store_addr[ADDR_W-1:OFF_W];
  assign w_ext_tag   = i_ext_inval_addr[ADDR_W-1:OFF_W];

  // A same-cycle store/invalidation on the SC's set is ordered first and kills it;
  // among survivors on one set the lowest channel wins, and each winner acts as
  // a store that knocks out every other holder of its set.
  always_comb begin
    w_eligible  = '0;
    w_win       = '0;
    w_peer_kill = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      w_eligible[i] = i_sc_valid[i] && w_sc_match[i] &&
                      !(i_store_valid && (w_store_tag == w_sc_tag[i])) &&
                      !(i_ext_inval_valid && (w_ext_tag == w_sc_tag[i]));
    end
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      w_win[i] = w_eligible[i];
      for (int j = 0; j < i; j++) begin
        if (w_eligible[j] && (w_sc_tag[j] == w_sc_tag[i])) w_win[i] = 1'b0;
      end
    end
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      for (int j = 0; j < NUM_CHANNELS; j++) begin
        if ((j != k) && w_win[j] && (w_sc_tag[j] == w_slot_tag[k])) w_peer_kill[k] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_slot
    amo_reservation_slot #(
      .LR_WAIT (LR_WAIT),
      .TAG_W   (TAG_W)
    ) u_slot (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_lr_valid    (i_lr_valid[g]),
      .i_lr_tag      (w_lr_tag[g]),
      .i_sc_valid    (i_sc_valid[g]),
      .i_sc_tag      (w_sc_tag[g]),
      .i_store_valid (i_store_valid),
      .i_store_tag   (w_store_tag),
      .i_ext_valid   (i_ext_inval_valid),
      .i_ext_tag     (w_ext_tag),
      .i_peer_kill   (w_peer_kill[g]),
      .o_reserved    (o_reservation_valid[g]),
      .o_tag         (w_slot_tag[g]),
      .o_sc_match    (w_sc_match[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sc_done    <= '0;
      r_sc_success <= '0;
    end else begin
      r_sc_done    <= i_sc_valid;
      r_sc_success <= w_win;
    end
  end

  assign o_sc_done    = r_sc_done;
  assign o_sc_success = r_sc_success;

  // Byte offsets inside a set never influence reservation matching.
  always_comb begin
    w_unused_offsets = i_store_addr[0] ^ i_ext_inval_addr[0];
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      w_unused_offsets = w_unused_offsets ^ (^i_lr_addr[i*ADDR_W +: OFF_W])
                                          ^ (^i_sc_addr[i*ADDR_W +: OFF_W]);
    end
    w_unused_offsets = w_unused_offsets ^ (^i_store_addr[OFF_W-1:0]) ^ (^i_ext_inval_addr[OFF_W-1:0]);
  end

endmodule

// File: tb/tb_amo_reservation_tracker.sv
// Directed bench for amo_reservation_tracker with default parameters (2 channels, LR_WAIT=32, 32B sets).
module tb_amo_reservation_tracker;

  logic        clk;
  logic        rst_n;
  logic [1:0]  lr_valid;
  logic [63:0] lr_addr;
  logic [1:0]  sc_valid;
  logic [63:0] sc_addr;
  logic [1:0]  sc_done;
  logic [1:0]  sc_success;
  logic        store_valid;
  logic [31:0] store_addr;
  logic        ext_valid;
  logic [31:0] ext_addr;
  logic [1:0]  res_valid;

  int errors;
  int checks;

  amo_reservation_tracker #(
    .NUM_CHANNELS      (2),
    .LR_WAIT           (32),
    .RESERVATION_WORDS (8),
    .ADDR_W            (32)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .i_lr_valid          (lr_valid),
    .i_lr_addr           (lr_addr),
    .i_sc_valid          (sc_valid),
    .i_sc_addr           (sc_addr),
    .o_sc_done           (sc_done),
    .o_sc_success        (sc_success),
    .i_store_valid       (store_valid),
    .i_store_addr        (store_addr),
    .i_ext_inval_valid   (ext_valid),
    .i_ext_inval_addr    (ext_addr),
    .o_reservation_valid (res_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clear_inputs();
    lr_valid    = '0;
    lr_addr     = '0;
    sc_valid    = '0;
    sc_addr     = '0;
    store_valid = 1'b0;
    store_addr  = '0;
    ext_valid   = 1'b0;
    ext_addr    = '0;
  endtask

  task automatic drive_lr(input int ch, input logic [31:0] addr);
    lr_valid[ch]         = 1'b1;
    lr_addr[ch*32 +: 32] = addr;
  endtask

  task automatic drive_sc(input int ch, input logic [31:0] addr);
    sc_valid[ch]         = 1'b1;
    sc_addr[ch*32 +: 32] = addr;
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (res_valid !== 2'b00) begin errors++; $display("[TB] FAIL reset_rv got=%b exp=00", res_valid); end
    checks++;
    if (sc_done !== 2'b00) begin errors++; $display("[TB] FAIL reset_done got=%b exp=00", sc_done); end
    checks++;
    if (sc_success !== 2'b00) begin errors++; $display("[TB] FAIL reset_succ got=%b exp=00", sc_success); end
  endtask

  task automatic test_lr_sc_basic();
    clear_inputs();
    drive_lr(0, 32'h8000_0010);
    tick(1);
    clear_inputs();
    checks++;
    if (res_valid !== 2'b01) begin errors++; $display("[TB] FAIL basic_rv_set got=%b exp=01", res_valid); end
    tick(4);
    drive_sc(0, 32'h8000_001C);
    tick(1);
    clear_inputs();
    checks++;
    if ({sc_done, sc_success} !== 4'b0101) begin errors++; $display("[TB] FAIL basic_sc got=%b/%b exp=01/01", sc_done, sc_success); end
    checks++;
    if (res_valid !== 2'b00) begin errors++; $display("[TB] FAIL basic_rv_clr got=%b exp=00", res_valid); end
    tick(1);
    checks++;
    if (sc_done !== 2'b00) begin errors++; $display("[TB] FAIL basic_done_pulse got=%b exp=00", sc_done); end
  endtask

  task automatic test_expiry();
    drive_lr(0, 32'h8000_0400);
    tick(1);
    clear_inputs();
    tick(31);
    drive_sc(0, 32'h8000_0400);
    tick(1);
    clear_inputs();
    checks++;
    if ({sc_done[0], sc_success[0]} !== 2'b11) begin errors++; $display("[TB] FAIL expiry_last_ok got=%b%b exp=11", sc_done[0], sc_success[0]); end
    drive_lr(0, 32'h8000_0400);
    tick(1);
    clear_inputs();
    tick(31);
    checks++;
    if (res_valid[0] !== 1'b1) begin errors++; $display("[TB] FAIL expiry_live_t32 got=%b exp=1", res_valid[0]); end
    tick(1);
    checks++;
    if (res_valid[0] !== 1'b0) begin errors++; $display("[TB] FAIL expiry_rv_t33 got=%b exp=0", res_valid[0]); end
    drive_sc(0, 32'h8000_0400);
    tick(1);
    clear_inputs();
    checks++;
    if ({sc_done[0], sc_success[0]} !== 2'b10) begin errors++; $display("[TB] FAIL expiry_late_sc got=%b%b exp=10", sc_done[0], sc_success[0]); end
  endtask

  task automatic test_sc_arbitration();
    drive_lr(0, 32'h8000_0040);
    drive_lr(1, 32'h8000_0040);
    tick(1);
    clear_inputs();
    checks++;
    if (res_valid !== 2'b11) begin errors++; $display("[TB] FAIL arb_rv_both got=%b exp=11", res_valid); end
    drive_sc(0, 32'h8000_0040);
    drive_sc(1, 32'h8000_0044);
    tick(1);
    clear_inputs();
    checks++;
    if ({sc_done, sc_success} !== 4'b1101) begin errors++; $display("[TB] FAIL arb_same_cycle got=%b/%b exp=11/01", sc_done, sc_success); end
    checks++;
    if (res_valid !== 2'b00) begin errors++; $display("[TB] FAIL arb_rv_clr got=%b exp=00", res_valid); end
    drive_lr(0, 32'h8000_0040);
    drive_lr(1, 32'h8000_0040);
    tick(1);
    clear_inputs();
    drive_sc(1, 32'h8000_0048);
    tick(1);
    clear_inputs();
    checks++;
    if ({sc_success, res_valid} !== 4'b1000) begin errors++; $display("[TB] FAIL arb_peer_kill got=%b/%b exp=10/00", sc_success, res_valid); end
  endtask

  task automatic test_store_invalidation();
    drive_lr(1, 32'h8000_0100);
    tick(2);
    clear_inputs();
    store_valid = 1'b1;
    store_addr  = 32'h8000_011C;
    tick(1);
    clear_inputs();
    checks++;
    if (res_valid[1] !== 1'b0) begin errors++; $display("[TB] FAIL store_kill_rv got=%b exp=0", res_valid[1]); end
    drive_sc(1, 32'h8000_0100);
    tick(1);
    clear_inputs();
    checks++;
    if ({sc_done[1], sc_success[1]} !== 2'b10) begin errors++; $display("[TB] FAIL store_kill_sc got=%b%b exp=10", sc_done[1], sc_success[1]); end
    drive_lr(1, 32'h8000_0100);
    tick(1);
    clear_inputs();
    store_valid = 1'b1;
    store_addr  = 32'h8000_0120;
    tick(1);
    clear_inputs();
    checks++;
    if (res_valid[1] !== 1'b1) begin errors++; $display("[TB] FAIL store_other_set_rv got=%b exp=1", res_valid[1]); end
    drive_sc(1, 32'h8000_0104);
    tick(1);
    clear_inputs();
    checks++;
    if (sc_success[1] !== 1'b1) begin errors++; $display("[TB] FAIL store_other_set_sc got=%b exp=1", sc_success[1]); end
  endtask

  task automatic test_ext_inval_order();
    drive_lr(0, 32'h8000_0800);
    ext_valid = 1'b1;
    ext_addr  = 32'h8000_0810;
    tick(1);
    clear_inputs();
    checks++;
    if (res_valid[0] !== 1'b1) begin errors++; $display("[TB] FAIL ext_lr_held got=%b exp=1", res_valid[0]); end
    drive_sc(0, 32'h8000_0800);
    ext_valid = 1'b1;
    ext_addr  = 32'h8000_081C;
    tick(1);
    clear_inputs();
    checks++;
    if ({sc_done[0], sc_success[0]} !== 2'b10) begin errors++; $display("[TB] FAIL ext_sc_killed got=%b%b exp=10", sc_done[0], sc_success[0]); end
  endtask

  task automatic test_lr_sc_same_channel();
    drive_lr(0, 32'h8000_0A00);
    tick(1);
    clear_inputs();
    drive_sc(0, 32'h8000_0A00);
    drive_lr(0, 32'h8000_0B00);
    tick(1);
    clear_inputs();
    checks++;
    if ({sc_success[0], res_valid[0]} !== 2'b11) begin errors++; $display("[TB] FAIL lrsc_same_ch got=%b%b exp=11", sc_success[0], res_valid[0]); end
    drive_sc(0, 32'h8000_0B08);
    tick(1);
    clear_inputs();
    checks++;
    if (sc_success[0] !== 1'b1) begin errors++; $display("[TB] FAIL lrsc_new_set got=%b exp=1", sc_success[0]); end
  endtask

  task automatic test_async_reset();
    drive_lr(0, 32'h8000_0200);
    drive_lr(1, 32'h8000_0300);
    tick(1);
    clear_inputs();
    drive_sc(1, 32'h8000_0300);
    tick(1);
    clear_inputs();
    checks++;
    if ({sc_done, sc_success, res_valid} !== 6'b10_10_01) begin errors++; $display("[TB] FAIL arst_pre got=%b/%b/%b exp=10/10/01", sc_done, sc_success, res_valid); end
    drive_sc(0, 32'h8000_0200);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sc_done, sc_success, res_valid} !== 6'b0) begin errors++; $display("[TB] FAIL arst_immediate got=%b/%b/%b exp=00/00/00", sc_done, sc_success, res_valid); end
    tick(1);
    checks++;
    if (sc_done !== 2'b00) begin errors++; $display("[TB] FAIL arst_dropped_done got=%b exp=00", sc_done); end
    clear_inputs();
    rst_n = 1'b1;
    drive_sc(0, 32'h8000_0200);
    tick(1);
    clear_inputs();
    checks++;
    if ({sc_done, sc_success} !== 4'b0100) begin errors++; $display("[TB] FAIL arst_sc_after got=%b/%b exp=01/00", sc_done, sc_success); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    clear_inputs();
    #12;
    test_reset();
    rst_n = 1'b1;
    tick(1);
    test_lr_sc_basic();
    test_expiry();
    test_sc_arbitration();
    test_store_invalidation();
    test_ext_inval_order();
    test_lr_sc_same_channel();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
